// File: rtl/cve2_obi_resp_pkg.sv
`default_nettype none
// ============================================================================
// cve2_obi_resp_pkg : shared types and helpers for the OBI memory responder
// Rev 1.0
// ============================================================================
package cve2_obi_resp_pkg;

  localparam int unsigned MaxLatency = 8;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_resp_t;

  // Offset form avoids overflow of base + span at the top of the address map.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned words);
    logic [31:0] span;
    span = 32'(words) << 2;
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cve2_obi_resp_fifo.sv
`default_nettype none
// ============================================================================
// cve2_obi_resp_fifo : in-order response queue; each entry ages one per cycle
// and the head is reported mature once it reaches the response latency.
// Rev 1.0
// ============================================================================
module cve2_obi_resp_fifo
  import cve2_obi_resp_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  obi_resp_t i_data,
  input  logic      i_pop,
  output logic      o_head_mature,
  output obi_resp_t o_head,
  output logic [3:0] o_count
);

  localparam int         PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] MATURE_AGE = 3'(LATENCY - 1);

  logic [DEPTH-1:0] r_vld;
  logic [2:0]       r_age  [DEPTH];
  obi_resp_t        r_data [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [3:0]       r_count;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i]) r_age[i] <= r_age[i] + 3'd1;
      end
      if (i_pop) begin
        r_vld[r_rd] <= 1'b0;
        r_rd        <= f_next(r_rd);
      end
      // The caller never pushes into a full queue, so the write slot is free.
      if (i_push) begin
        r_vld[r_wr] <= 1'b1;
        r_age[r_wr] <= '0;
        r_wr        <= f_next(r_wr);
      end
      r_count <= r_count + 4'(i_push) - 4'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_data[r_wr] <= i_data;
  end

  assign o_head_mature = r_vld[r_rd] && (r_age[r_rd] == MATURE_AGE);
  assign o_head        = r_data[r_rd];
  assign o_count       = r_count;

endmodule
`default_nettype wire

// File: rtl/cve2_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// cve2_obi_mem_responder : OBI req/gnt/rvalid memory responder with fixed
// response latency, bounded outstanding requests and out-of-range errors.
// Rev 1.0
// ============================================================================
module cve2_obi_mem_responder
  import cve2_obi_resp_pkg::*;
#(
  parameter int          MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int          RespLatency    = 1,
  parameter int          MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        stall_i,
  output logic [3:0]  outstanding_o
);

  localparam int IDX_W = $clog2(MemWords);

  logic [31:0]      r_mem [MemWords];
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic             w_xfer;
  logic             w_mature;
  logic             w_rvalid;
  logic [3:0]       w_count;
  obi_resp_t        w_push_data;
  obi_resp_t        w_head;

  assign w_in_range = addr_in_range(addr_i, BaseAddr, int'(MemWords));
  assign w_idx      = IDX_W'((addr_i - BaseAddr) >> 2);

  // Grant depends only on registered count and control inputs, never on address.
  assign gnt_o  = req_i & ~stall_i & ~rst_i & (w_count < 4'(MaxOutstanding));
  assign w_xfer = req_i & gnt_o;

  assign w_push_data.rdata = (!we_i && w_in_range) ? r_mem[w_idx] : 32'h0;
  assign w_push_data.err   = ~w_in_range;

  always_ff @(posedge clk_i) begin
    if (w_xfer && we_i && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  cve2_obi_resp_fifo #(
    .DEPTH   (MaxOutstanding),
    .LATENCY (RespLatency)
  ) u_resp_fifo (
    .clk           (clk_i),
    .rst           (rst_i),
    .i_push        (w_xfer),
    .i_data        (w_push_data),
    .i_pop         (w_rvalid),
    .o_head_mature (w_mature),
    .o_head        (w_head),
    .o_count       (w_count)
  );

  // A response maturing while reset is asserted is dropped along with the queue.
  assign w_rvalid      = w_mature & ~rst_i;
  assign rvalid_o      = w_rvalid;
  assign rdata_o       = w_rvalid ? w_head.rdata : 32'h0;
  assign err_o         = w_rvalid ? w_head.err : 1'b0;
  assign outstanding_o = w_count;

endmodule
`default_nettype wire

// File: tb/tb_cve2_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_cve2_obi_mem_responder : scoreboard bench with a reference memory model
// Rev 1.0
// ============================================================================
module tb_cve2_obi_mem_responder;

  localparam int          MEMW = 1024;
  localparam int          LAT  = 3;
  localparam int          MAXO = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk_i;
  logic        rst_i;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        stall_i;
  logic [3:0]  outstanding_o;

  cve2_obi_mem_responder #(
    .MemWords       (MEMW),
    .BaseAddr       (BASE),
    .RespLatency    (LAT),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .addr_i        (addr_i),
    .we_i          (we_i),
    .be_i          (be_i),
    .wdata_i       (wdata_i),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .stall_i       (stall_i),
    .outstanding_o (outstanding_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          due_q[$];
  logic [31:0] mm [MEMW];

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(MEMW * 4));
  endfunction

  // One bus cycle: drive at posedge+1, judge grant and count at posedge+4.
  task automatic tick(input bit req, input bit we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      input bit stall, output bit g);
    int          pending;
    bit          exp_g;
    bit          ok;
    logic [9:0]  idx;
    logic [31:0] rd;
    req_i = req; we_i = we; addr_i = addr; be_i = be; wdata_i = wd; stall_i = stall;
    #3;
    while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
    pending = due_q.size();
    exp_g = req && !stall && (pending < MAXO);
    checks++;
    if (gnt_o !== exp_g) begin
      errors++;
      $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt_o, exp_g);
    end
    checks++;
    if (outstanding_o !== 4'(pending)) begin
      errors++;
      $display("FAIL outstanding cyc=%0d got=%0d exp=%0d", cyc, outstanding_o, pending);
    end
    g = req && (gnt_o === 1'b1);
    if (g) begin
      ok  = in_rng(addr);
      idx = 10'((addr - BASE) >> 2);
      rd  = (ok && !we) ? mm[idx] : 32'h0;
      exp_q.push_back('{rdata: rd, err: !ok, due: cyc + LAT});
      due_q.push_back(cyc + LAT);
      if (ok && we) begin
        for (int b = 0; b < 4; b++) if (be[b]) mm[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    bit g;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, g);
  endtask

  task automatic xfer(input bit we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd);
    bit g;
    g = 1'b0;
    for (int k = 0; k < 16 && !g; k++) tick(1'b1, we, addr, be, wd, 1'b0, g);
    checks++;
    if (!g) begin
      errors++;
      $display("FAIL xfer_timeout addr=%h got=no_grant exp=grant", addr);
    end
    req_i = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1; req_i = 1'b1; stall_i = 1'b0;
    exp_q.delete();
    due_q.delete();
    for (int i = 0; i < n; i++) begin
      #3;
      checks++;
      if (gnt_o !== 1'b0 || rvalid_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet gnt=%b rvalid=%b exp=0/0", gnt_o, rvalid_o);
      end
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b0; req_i = 1'b0;
  endtask

  // Monitor: every falling edge either matches a scoreboard entry or sees idle zeros.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (rvalid_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_rvalid cyc=%0d got=rvalid exp=none", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.due != cyc || rdata_o !== e.rdata || err_o !== e.err) begin
            errors++;
            $display("FAIL resp cyc=%0d got rdata=%h err=%b exp rdata=%h err=%b due=%0d",
                     cyc, rdata_o, err_o, e.rdata, e.err, e.due);
          end
        end
      end else begin
        checks++;
        if (rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs cyc=%0d got rvalid=%b rdata=%h err=%b exp=0", cyc,
                   rvalid_o, rdata_o, err_o);
        end
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_rvalid cyc=%0d got=none exp_due=%0d", cyc, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit g;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
    stall_i = 1'b0;
    @(posedge clk_i);
    #1;
    mon_en = 1'b1;
    do_reset(2);

    xfer(1'b1, 32'h0, 4'hF, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h0, 4'h0, 32'h0);

    xfer(1'b1, 32'h10, 4'hF, 32'h1122_3344);
    xfer(1'b1, 32'h10, 4'b0101, 32'hAABB_CCDD);
    xfer(1'b0, 32'h10, 4'h0, 32'h0);
    idle(LAT + 1);

    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, g);
    req_i = 1'b0;
    idle(LAT + 1);

    xfer(1'b1, 32'hFFC, 4'hF, 32'hCAFE_F00D);
    xfer(1'b0, 32'h1000, 4'h0, 32'h0);
    xfer(1'b1, 32'h1000, 4'hF, 32'h5555_5555);
    xfer(1'b0, 32'hFFC, 4'h0, 32'h0);
    idle(LAT + 1);

    xfer(1'b0, 32'h10, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b1, g);
    tick(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0, g);
    req_i = 1'b0;
    idle(LAT + 1);

    for (int w = 0; w < 64; w++) xfer(1'b1, 32'(w * 4), 4'hF, $urandom);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + ($urandom & 32'h00FF_FFFF);
      else a = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3));
      tick($urandom_range(0, 3) != 0, 1'($urandom), a, 4'($urandom), $urandom,
           $urandom_range(0, 7) == 0, g);
    end
    req_i = 1'b0;
    idle(LAT + 1);

    xfer(1'b1, 32'h20, 4'hF, 32'h0BAD_CAFE);
    idle(LAT + 1);
    xfer(1'b0, 32'h20, 4'h0, 32'h0);
    xfer(1'b0, 32'h24, 4'h0, 32'h0);
    do_reset(1);
    idle(LAT + 3);
    xfer(1'b0, 32'h20, 4'h0, 32'h0);
    idle(LAT + 2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d_pending exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
